operand_feeder: RTL and testbench
=================================

// Module: operand_feeder
// PURPOSE
//  Operand source for the 3x3 systolic MAC array; answers the array's per-lane read enables.
//  Host preloads matrix A (N rows x K elements) and matrix B (M columns x K elements) through a write port.
//  On start, it serves one element per lane per asserted read enable, in index order.
//  It raises finished once every lane has been fully consumed.
// PARAMETERS
//  DATA_WIDTH  32  operand width in bits
//  N           3   A lanes (array rows)
//  M           3   B lanes (array columns)
//  K           3   elements per lane (inner dimension); K >= 1
// PORTS
//  clk        in   1             clock, all logic on posedge
//  rst        in   1             synchronous, active-high reset
//  wr_en      in   1             host write strobe (honoured in IDLE/DONE only)
//  wr_sel     in   1             0 = A memory, 1 = B memory
//  wr_lane    in   clog2(max(N,M))  lane index
//  wr_idx     in   clog2(K)      element index within lane
//  wr_data    in   DATA_WIDTH    element value
//  start      in   1             1-cycle pulse: begin serving
//  a_rd_en    in   N             per-lane A read enable from array control
//  b_rd_en    in   M             per-lane B read enable from array control
//  a_data     out  N*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH], show-ahead
//  b_data     out  M*DATA_WIDTH  lane j at [j*DATA_WIDTH +: DATA_WIDTH], show-ahead
//  finished   out  1             level: all lanes consumed
//  busy       out  1             high in SERVE
//  err        out  1             sticky protocol error flag
// BEHAVIOUR
//  FSM IDLE -> SERVE (start) -> DONE (all ptrs == K) -> SERVE (start) ...; rst -> IDLE from any state.
//  Reset values: state IDLE, all a_ptr/b_ptr 0, finished 0, busy 0, err 0; a_data/b_data 0.
//  Memories are not cleared by reset; contents persist across runs.
//  Write: in IDLE/DONE with wr_en, mem[wr_sel][wr_lane][wr_idx] <= wr_data next edge.
//  Out-of-range wr_lane/wr_idx: write dropped, err set.
//  Write in SERVE: dropped, err set.
//  start in IDLE/DONE: all ptrs <= 0, state <= SERVE, finished <= 0.
//  start in SERVE: ignored, err set.
//  wr_en and start in the same cycle (IDLE/DONE): write lands and serving begins; the written value is visible on the first read.
//  Data, SERVE only: lane i a_data = A[i][a_ptr[i]] combinationally from registered ptr.
//  Data is 0 when ptr == K or state != SERVE; same rules for b_data.
//  Read consume: on the edge where a_rd_en[i]=1 in SERVE with a_ptr[i] < K, the consumer samples the current element and a_ptr[i] increments.
//  Each lane is independent, so any skew pattern is legal.
//  Read with ptr == K (underflow): ptr holds, data 0, err set; read enables outside SERVE are ignored and do not set err.
//  Completion: when every a_ptr and b_ptr == K (registered compare), state -> DONE and finished = 1 on the following edge.
//  finished and busy are registered outputs, so finished rises 1 cycle after the last consuming edge.
//  finished holds until the next start or rst.
//  err clears only on rst.
//  Reset mid-SERVE: next edge IDLE, ptrs 0, finished 0, busy 0, outputs 0; memory intact, so a new start replays the same data.
// TESTING
//  1. Load A[i][k]=10*i+k, B[j][k]=100*j+k; start; assert all rd_en each cycle.
//     -> lanes show k=0,1,2 on 3 consecutive edges; finished=1 exactly 1 cycle after 3rd read; err=0.
//  2. Skewed enables (lane i starts i cycles late, array pattern).
//     -> each lane still yields its elements in order 0..K-1; finished 1 cycle after lane 2 last read.
//  3. After finished, extra a_rd_en[0] in DONE -> ignored, err=0.
//     Force underflow during SERVE (one lane overread) -> data 0, ptr holds at 3, err=1 sticky.
//  4. wr_en during SERVE with wr_data=0xDEAD -> memory unchanged (replay after start shows old value), err=1.
//  5. rst asserted after 2 reads -> next cycle busy=0, outputs 0.
//     start again -> lanes restart at k=0 with original data.
//  6. Same-cycle wr_en (A[0][0]=0x55) + start in DONE -> first a_data lane 0 = 0x55; second start during SERVE -> ignored, err=1.

Source files
------------

// File: rtl/operand_feeder.sv
// rtl/operand_feeder.sv - per-lane show-ahead operand source for the 3x3 systolic MAC array
module operand_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 3,
  parameter int M          = 3,
  parameter int K          = 3,
  localparam int NM        = (N > M) ? N : M,
  localparam int LW        = (NM > 1) ? $clog2(NM) : 1,
  localparam int IW        = (K > 1) ? $clog2(K) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    wr_sel,
  input  logic [LW-1:0]           wr_lane,
  input  logic [IW-1:0]           wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    start,
  input  logic [N-1:0]            a_rd_en,
  input  logic [M-1:0]            b_rd_en,
  output logic [N*DATA_WIDTH-1:0] a_data,
  output logic [M*DATA_WIDTH-1:0] b_data,
  output logic                    finished,
  output logic                    busy,
  output logic                    err
);

  // Pointers must be able to hold K itself, which marks a fully consumed lane.
  localparam int PW = $clog2(K + 1);

  localparam logic [LW:0]   N_LIM = N[LW:0];
  localparam logic [LW:0]   M_LIM = M[LW:0];
  localparam logic [IW:0]   K_IDX = K[IW:0];
  localparam logic [PW-1:0] K_PTR = K[PW-1:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0] a_ptr_q [N];
  logic [PW-1:0] a_ptr_d [N];
  logic [PW-1:0] b_ptr_q [M];
  logic [PW-1:0] b_ptr_d [M];

  logic finished_q, finished_d;
  logic busy_q, busy_d;
  logic err_q, err_d;

  // Operand storage is deliberately left out of reset so a restart replays the same data.
  logic [DATA_WIDTH-1:0] a_mem_q [N][K];
  logic [DATA_WIDTH-1:0] b_mem_q [M][K];

  logic a_wr, b_wr;
  logic lane_ok, idx_ok;
  logic all_done;

  // All lanes consumed, judged from the registered pointers only.
  always_comb begin
    all_done = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (a_ptr_q[i] != K_PTR) all_done = 1'b0;
    end
    for (int j = 0; j < M; j++) begin
      if (b_ptr_q[j] != K_PTR) all_done = 1'b0;
    end
  end

  // Next-state logic: host writes, start handling, per-lane consumption and completion.
  always_comb begin
    state_d    = state_q;
    a_ptr_d    = a_ptr_q;
    b_ptr_d    = b_ptr_q;
    finished_d = finished_q;
    err_d      = err_q;
    a_wr       = 1'b0;
    b_wr       = 1'b0;

    lane_ok = wr_sel ? ({1'b0, wr_lane} < M_LIM) : ({1'b0, wr_lane} < N_LIM);
    idx_ok  = ({1'b0, wr_idx} < K_IDX);

    // Writes are only accepted while nothing is being served; bad addresses never land.
    if (wr_en) begin
      if ((state_q == SERVE) || !lane_ok || !idx_ok) begin
        err_d = 1'b1;
      end else if (wr_sel) begin
        b_wr = 1'b1;
      end else begin
        a_wr = 1'b1;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          for (int i = 0; i < N; i++) a_ptr_d[i] = '0;
          for (int j = 0; j < M; j++) b_ptr_d[j] = '0;
          finished_d = 1'b0;
          state_d    = SERVE;
        end
      end
      SERVE: begin
        if (start) err_d = 1'b1;
        // Lanes advance independently; reading an exhausted lane is an underflow.
        for (int i = 0; i < N; i++) begin
          if (a_rd_en[i]) begin
            if (a_ptr_q[i] < K_PTR) a_ptr_d[i] = a_ptr_q[i] + PW'(1);
            else                    err_d = 1'b1;
          end
        end
        for (int j = 0; j < M; j++) begin
          if (b_rd_en[j]) begin
            if (b_ptr_q[j] < K_PTR) b_ptr_d[j] = b_ptr_q[j] + PW'(1);
            else                    err_d = 1'b1;
          end
        end
        if (all_done) begin
          state_d    = DONE;
          finished_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SERVE);
  end

  // Control state, pointers and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      finished_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < N; i++) a_ptr_q[i] <= '0;
      for (int j = 0; j < M; j++) b_ptr_q[j] <= '0;
    end else begin
      state_q    <= state_d;
      finished_q <= finished_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      a_ptr_q    <= a_ptr_d;
      b_ptr_q    <= b_ptr_d;
    end
  end

  // Operand memory write port; a write issued with start is visible on the first read.
  always_ff @(posedge clk) begin
    if (a_wr) a_mem_q[wr_lane][wr_idx] <= wr_data;
    if (b_wr) b_mem_q[wr_lane][wr_idx] <= wr_data;
  end

  // Show-ahead lane data, forced to zero outside SERVE or once a lane is exhausted.
  always_comb begin
    a_data = '0;
    b_data = '0;
    if (state_q == SERVE) begin
      for (int i = 0; i < N; i++) begin
        if (a_ptr_q[i] < K_PTR) a_data[i*DATA_WIDTH +: DATA_WIDTH] = a_mem_q[i][a_ptr_q[i][IW-1:0]];
      end
      for (int j = 0; j < M; j++) begin
        if (b_ptr_q[j] < K_PTR) b_data[j*DATA_WIDTH +: DATA_WIDTH] = b_mem_q[j][b_ptr_q[j][IW-1:0]];
      end
    end
  end

  assign finished = finished_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_operand_feeder.sv
// tb/tb_operand_feeder.sv - directed self-checking bench for operand_feeder
module tb_operand_feeder;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic          wr_sel;
  logic [1:0]    wr_lane;
  logic [1:0]    wr_idx;
  logic [DW-1:0] wr_data;
  logic          start;
  logic [2:0]    a_rd_en;
  logic [2:0]    b_rd_en;
  logic [3*DW-1:0] a_data;
  logic [3*DW-1:0] b_data;
  logic          finished;
  logic          busy;
  logic          err;

  int vecs = 0;
  int errs = 0;

  operand_feeder #(.DATA_WIDTH(DW), .N(3), .M(3), .K(3)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_lane(wr_lane), .wr_idx(wr_idx), .wr_data(wr_data),
    .start(start), .a_rd_en(a_rd_en), .b_rd_en(b_rd_en),
    .a_data(a_data), .b_data(b_data),
    .finished(finished), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] a_lane(input int i);
    return a_data[i*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] b_lane(input int j);
    return b_data[j*DW +: DW];
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_elem(input logic sel, input int lane, input int idx, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_lane = lane[1:0]; wr_idx = idx[1:0]; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain_all;
    a_rd_en = 3'b111; b_rd_en = 3'b111;
    repeat (3) tick();
    a_rd_en = 3'b000; b_rd_en = 3'b000;
  endtask

  task automatic wait_finished(input string name);
    int n;
    n = 0;
    while (finished !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    vecs++;
    if (finished !== 1'b1) begin
      errs++;
      $display("FAIL %s: finished=%b after %0d cycles, required 1", name, finished, n);
    end
  endtask

  task automatic test_reset;
    vecs++;
    if (busy !== 1'b0 || finished !== 1'b0 || err !== 1'b0) begin
      errs++;
      $display("FAIL reset_flags: busy=%b finished=%b err=%b, required 0 0 0", busy, finished, err);
    end
    vecs++;
    if (a_data !== '0 || b_data !== '0) begin
      errs++;
      $display("FAIL reset_data: a=%h b=%h, required 0", a_data, b_data);
    end
  endtask

  task automatic load_all;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++) begin
        write_elem(1'b0, i, k, DW'(10*i + k));
        write_elem(1'b1, i, k, DW'(100*i + k));
      end
  endtask

  task automatic test_full_rate;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if (busy !== 1'b1) begin
        errs++;
        $display("FAIL full_busy k=%0d: got %b, required 1", k, busy);
      end
      for (int i = 0; i < 3; i++) begin
        vecs++;
        if (a_lane(i) !== DW'(10*i + k) || b_lane(i) !== DW'(100*i + k)) begin
          errs++;
          $display("FAIL full_data lane=%0d k=%0d: a=%0d b=%0d, required %0d %0d",
                   i, k, a_lane(i), b_lane(i), 10*i + k, 100*i + k);
        end
      end
      a_rd_en = 3'b111; b_rd_en = 3'b111;
      tick();
    end
    a_rd_en = 3'b000; b_rd_en = 3'b000;
    vecs++;
    if (finished !== 1'b0 || a_data !== '0 || b_data !== '0) begin
      errs++;
      $display("FAIL full_after_last: finished=%b a=%h b=%h, required 0 0 0", finished, a_data, b_data);
    end
    tick();
    vecs++;
    if (finished !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      errs++;
      $display("FAIL full_done: finished=%b busy=%b err=%b, required 1 0 0", finished, busy, err);
    end
  endtask

  task automatic test_skewed;
    logic [2:0] en;
    int p;
    logic [DW-1:0] ea, eb;
    pulse_start();
    for (int c = 0; c < 7; c++) begin
      en = 3'b000;
      for (int i = 0; i < 3; i++) begin
        p = (c < i) ? 0 : (((c - i) > 3) ? 3 : (c - i));
        ea = (p == 3) ? '0 : DW'(10*i + p);
        eb = (p == 3) ? '0 : DW'(100*i + p);
        vecs++;
        if (a_lane(i) !== ea || b_lane(i) !== eb) begin
          errs++;
          $display("FAIL skew_data c=%0d lane=%0d: a=%0d b=%0d, required %0d %0d",
                   c, i, a_lane(i), b_lane(i), ea, eb);
        end
        en[i] = (c >= i) && (c < i + 3);
      end
      if (c == 5) begin
        vecs++;
        if (finished !== 1'b0) begin
          errs++;
          $display("FAIL skew_early_finish: got %b, required 0", finished);
        end
      end
      if (c == 6) begin
        vecs++;
        if (finished !== 1'b1 || err !== 1'b0) begin
          errs++;
          $display("FAIL skew_finish: finished=%b err=%b, required 1 0", finished, err);
        end
      end
      a_rd_en = en; b_rd_en = en;
      tick();
    end
    a_rd_en = 3'b000; b_rd_en = 3'b000;
  endtask

  task automatic test_underflow;
    a_rd_en = 3'b001;
    tick();
    a_rd_en = 3'b000;
    vecs++;
    if (err !== 1'b0 || finished !== 1'b1) begin
      errs++;
      $display("FAIL done_read_ignored: err=%b finished=%b, required 0 1", err, finished);
    end
    pulse_start();
    a_rd_en = 3'b001;
    repeat (3) tick();
    vecs++;
    if (a_lane(0) !== '0 || err !== 1'b0 || a_lane(1) !== DW'(10)) begin
      errs++;
      $display("FAIL lane0_exhausted: a0=%0d a1=%0d err=%b, required 0 10 0", a_lane(0), a_lane(1), err);
    end
    tick();
    a_rd_en = 3'b000;
    vecs++;
    if (err !== 1'b1 || a_lane(0) !== '0 || a_lane(1) !== DW'(10)) begin
      errs++;
      $display("FAIL underflow: err=%b a0=%0d a1=%0d, required 1 0 10", err, a_lane(0), a_lane(1));
    end
    tick();
    vecs++;
    if (err !== 1'b1) begin
      errs++;
      $display("FAIL err_sticky: got %b, required 1", err);
    end
    a_rd_en = 3'b110; b_rd_en = 3'b111;
    repeat (3) tick();
    a_rd_en = 3'b000; b_rd_en = 3'b000;
    wait_finished("underflow_finish");
  endtask

  task automatic test_bad_write;
    do_reset();
    write_elem(1'b0, 3, 0, 32'h0BAD);
    vecs++;
    if (err !== 1'b1) begin
      errs++;
      $display("FAIL bad_lane_err: got %b, required 1", err);
    end
    do_reset();
    write_elem(1'b1, 0, 3, 32'h0BAD);
    vecs++;
    if (err !== 1'b1) begin
      errs++;
      $display("FAIL bad_idx_err: got %b, required 1", err);
    end
  endtask

  task automatic test_write_in_serve;
    do_reset();
    vecs++;
    if (err !== 1'b0 || busy !== 1'b0 || finished !== 1'b0) begin
      errs++;
      $display("FAIL rst_clears: err=%b busy=%b finished=%b, required 0 0 0", err, busy, finished);
    end
    pulse_start();
    write_elem(1'b0, 1, 0, 32'hDEAD);
    vecs++;
    if (err !== 1'b1 || a_lane(1) !== DW'(10)) begin
      errs++;
      $display("FAIL serve_write: err=%b a1=%h, required 1 a", err, a_lane(1));
    end
    drain_all();
    wait_finished("serve_write_finish");
    pulse_start();
    vecs++;
    if (a_lane(1) !== DW'(10)) begin
      errs++;
      $display("FAIL serve_write_replay: a1=%h, required a", a_lane(1));
    end
    drain_all();
    wait_finished("replay_finish");
  endtask

  task automatic test_reset_mid_serve;
    do_reset();
    pulse_start();
    a_rd_en = 3'b111; b_rd_en = 3'b111;
    repeat (2) tick();
    a_rd_en = 3'b000; b_rd_en = 3'b000;
    vecs++;
    if (a_lane(2) !== DW'(22) || b_lane(1) !== DW'(102)) begin
      errs++;
      $display("FAIL mid_serve_data: a2=%0d b1=%0d, required 22 102", a_lane(2), b_lane(1));
    end
    do_reset();
    vecs++;
    if (busy !== 1'b0 || finished !== 1'b0 || a_data !== '0 || b_data !== '0) begin
      errs++;
      $display("FAIL mid_reset: busy=%b finished=%b a=%h b=%h, required 0 0 0 0",
               busy, finished, a_data, b_data);
    end
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (a_lane(i) !== DW'(10*i) || b_lane(i) !== DW'(100*i)) begin
        errs++;
        $display("FAIL restart lane=%0d: a=%0d b=%0d, required %0d %0d",
                 i, a_lane(i), b_lane(i), 10*i, 100*i);
      end
    end
    drain_all();
    wait_finished("restart_finish");
  endtask

  task automatic test_write_with_start;
    wr_en = 1'b1; wr_sel = 1'b0; wr_lane = 2'd0; wr_idx = 2'd0; wr_data = 32'h55;
    start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    vecs++;
    if (a_lane(0) !== 32'h55 || a_lane(2) !== DW'(20) || err !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL write_start: a0=%h a2=%0d err=%b busy=%b, required 55 20 0 1",
               a_lane(0), a_lane(2), err, busy);
    end
    pulse_start();
    vecs++;
    if (err !== 1'b1 || busy !== 1'b1 || a_lane(0) !== 32'h55) begin
      errs++;
      $display("FAIL start_in_serve: err=%b busy=%b a0=%h, required 1 1 55", err, busy, a_lane(0));
    end
  endtask

  initial begin
    wr_en = 1'b0; wr_sel = 1'b0; wr_lane = '0; wr_idx = '0; wr_data = '0;
    start = 1'b0; a_rd_en = '0; b_rd_en = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    load_all();
    test_full_rate();
    test_skewed();
    test_underflow();
    test_bad_write();
    test_write_in_serve();
    test_reset_mid_serve();
    test_write_with_start();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
